// File: rtl/snn_seq_pkg.sv
// Shared types, sizes and helpers for the SNN inference sequencer.
// The optional early-stop feature is enabled with SNN_SEQ_EARLY_STOP_EN.
package snn_seq_pkg;

    localparam int N                = 256;
    localparam int M                = 8;
    localparam int IMAGE_SIZE       = 256;
    localparam int PIXEL_BITS       = 8;
    localparam int TS_BITS          = 4;
    localparam int T_STEPS          = 2 ** TS_BITS;
    localparam int N_CLASSES        = 10;
    localparam int CNT_BITS         = 8;
    localparam int EARLY_STOP_COUNT = 8;
    localparam int CLS_W            = $clog2(N_CLASSES);

    localparam logic [M-1:0] NO_RESULT = 8'hFF;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        TICK,
        WAIT_CORE,
        ARGMAX,
        DONE
    } seq_state_t;

    // Rate coding: the upper nibble of a pixel is the number of timesteps it fires on.
    function automatic logic pixel_fires(input logic [PIXEL_BITS-1:0] pixel,
                                         input logic [TS_BITS-1:0]    t);
        return pixel[PIXEL_BITS-1 -: TS_BITS] > t;
    endfunction

endpackage

// File: rtl/snn_class_counter_bank.sv
// Per-class saturating spike counters with a single read port for the argmax scan.
// With SNN_SEQ_EARLY_STOP_EN the bank also flags any class reaching the stop count.
module snn_class_counter_bank
    import snn_seq_pkg::*;
(
    input  logic                ACLK,
    input  logic                ARESET,
    input  logic                clr,
    input  logic                inc_en,
    input  logic                inc_vld,
    input  logic [M-1:0]        inc_addr,
    input  logic [CLS_W-1:0]    rd_idx,
    output logic [CNT_BITS-1:0] rd_cnt
`ifdef SNN_SEQ_EARLY_STOP_EN
    ,
    output logic                hit
`endif
);

    logic [CNT_BITS-1:0] cnt [N_CLASSES];

    function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    // Addresses beyond the output layer are compared at full width so aliases never count.
    always_ff @(posedge ACLK) begin
        if (ARESET || clr) begin
            for (int i = 0; i < N_CLASSES; i++) cnt[i] <= '0;
        end else if (inc_en && inc_vld && (inc_addr < M'(N_CLASSES))) begin
            cnt[inc_addr[CLS_W-1:0]] <= sat_inc(cnt[inc_addr[CLS_W-1:0]]);
        end
    end

    assign rd_cnt = cnt[rd_idx];

`ifdef SNN_SEQ_EARLY_STOP_EN
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < N_CLASSES; i++) begin
            if (cnt[i] >= CNT_BITS'(EARLY_STOP_COUNT)) hit = 1'b1;
        end
    end
`endif

endmodule

// File: rtl/snn_inference_sequencer.sv
// Runs one rate-coded SNN inference per new image and returns the argmax class.
// Define SNN_SEQ_EARLY_STOP_EN to end a run once any class reaches EARLY_STOP_COUNT.
module snn_inference_sequencer
    import snn_seq_pkg::*;
(
    input  logic                                  ACLK,
    input  logic                                  ARESET,
    input  logic [IMAGE_SIZE-1:0][PIXEL_BITS-1:0] IMAGE,
    input  logic                                  NEW_IMAGE,
    output logic                                  EVT_VALID,
    output logic [M-1:0]                          EVT_ADDR,
    input  logic                                  EVT_READY,
    output logic                                  TICK,
    input  logic                                  CORE_BUSY,
    input  logic                                  OUT_SPK_VALID,
    input  logic [M-1:0]                          OUT_SPK_ADDR,
    output logic [M-1:0]                          INFERED_DIGIT,
    output logic                                  COP_RDY
);

    seq_state_t          state;
    logic [M-1:0]        p;
    logic [M-1:0]        p_next;
    logic [TS_BITS-1:0]  t;
    logic [TS_BITS-1:0]  t_next;
    logic                new_prev;
    logic                start;
    logic                cnt_en;
    logic                retire;
    logic                last_pixel;
    logic                last_step;
    logic                leave_early;
    logic [CLS_W-1:0]    arg_idx;
    logic [CNT_BITS-1:0] best_val;
    logic [M-1:0]        best_idx;
    logic [CNT_BITS-1:0] rd_cnt;
`ifdef SNN_SEQ_EARLY_STOP_EN
    logic                cnt_hit;
    logic                stop_flag;
`endif

    assign start      = NEW_IMAGE & ~new_prev & ((state == IDLE) || (state == DONE));
    assign cnt_en     = (state == SCAN) || (state == snn_seq_pkg::TICK) || (state == WAIT_CORE);
    assign retire     = ~EVT_VALID | EVT_READY;
    assign last_pixel = (p == M'(IMAGE_SIZE - 1));
    assign last_step  = (t == TS_BITS'(T_STEPS - 1));
    assign p_next     = p + 1'b1;
    assign t_next     = t + 1'b1;
    assign EVT_ADDR   = p;

    snn_class_counter_bank u_bank (
        .ACLK     (ACLK),
        .ARESET   (ARESET),
        .clr      (start),
        .inc_en   (cnt_en),
        .inc_vld  (OUT_SPK_VALID),
        .inc_addr (OUT_SPK_ADDR),
        .rd_idx   (arg_idx),
        .rd_cnt   (rd_cnt)
`ifdef SNN_SEQ_EARLY_STOP_EN
        ,
        .hit      (cnt_hit)
`endif
    );

`ifdef SNN_SEQ_EARLY_STOP_EN
    always_ff @(posedge ACLK) begin
        if (ARESET || start) begin
            stop_flag <= 1'b0;
        end else if (cnt_en && cnt_hit) begin
            stop_flag <= 1'b1;
        end
    end

    assign leave_early = stop_flag | (cnt_en & cnt_hit);
`else
    assign leave_early = 1'b0;
`endif

    // Argmax datapath re-arms itself whenever the FSM is outside ARGMAX.
    always_ff @(posedge ACLK) begin
        if (state != ARGMAX) begin
            arg_idx  <= '0;
            best_val <= '0;
            best_idx <= NO_RESULT;
        end else begin
            arg_idx <= arg_idx + 1'b1;
            if (rd_cnt > best_val) begin
                best_val <= rd_cnt;
                best_idx <= M'(arg_idx);
            end
        end
    end

    // EVT_VALID is looked ahead for pixel p so a firing pixel can retire every cycle.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state         <= IDLE;
            p             <= '0;
            t             <= '0;
            new_prev      <= 1'b0;
            EVT_VALID     <= 1'b0;
            TICK          <= 1'b0;
            INFERED_DIGIT <= NO_RESULT;
            COP_RDY       <= 1'b1;
        end else begin
            new_prev <= NEW_IMAGE;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        p             <= '0;
                        t             <= '0;
                        INFERED_DIGIT <= NO_RESULT;
                        COP_RDY       <= 1'b0;
                        EVT_VALID     <= pixel_fires(IMAGE[0], '0);
                        state         <= SCAN;
                    end
                end
                SCAN: begin
                    if (retire) begin
                        if (last_pixel) begin
                            p         <= '0;
                            EVT_VALID <= 1'b0;
                            TICK      <= 1'b1;
                            state     <= snn_seq_pkg::TICK;
                        end else begin
                            p         <= p_next;
                            EVT_VALID <= pixel_fires(IMAGE[p_next], t);
                        end
                    end
                end
                snn_seq_pkg::TICK: begin
                    TICK  <= 1'b0;
                    state <= WAIT_CORE;
                end
                WAIT_CORE: begin
                    if (!CORE_BUSY) begin
                        if (last_step || leave_early) begin
                            state <= ARGMAX;
                        end else begin
                            t         <= t_next;
                            EVT_VALID <= pixel_fires(IMAGE[0], t_next);
                            state     <= SCAN;
                        end
                    end
                end
                ARGMAX: begin
                    if (arg_idx == CLS_W'(N_CLASSES - 1)) begin
                        INFERED_DIGIT <= (rd_cnt > best_val) ? M'(arg_idx) : best_idx;
                        COP_RDY       <= 1'b1;
                        state         <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_snn_inference_sequencer.sv
// Directed-vector bench for snn_inference_sequencer with hand-computed expectations.
module tb_snn_inference_sequencer;

    logic                  clk = 1'b0;
    logic                  areset = 1'b1;
    logic [255:0][7:0]     image;
    logic                  new_image = 1'b0;
    logic                  evt_valid;
    logic [7:0]            evt_addr;
    logic                  evt_ready = 1'b1;
    logic                  tick;
    logic                  core_busy = 1'b0;
    logic                  out_spk_valid = 1'b0;
    logic [7:0]            out_spk_addr = 8'd0;
    logic [7:0]            infered_digit;
    logic                  cop_rdy;

    int n_chk = 0;
    int n_fail = 0;
    int evt_cnt, valid_cycles, tick_cnt, tick_err, stall_err, stall_seen, busy_overlap;
    int busy_left = 0;
    bit rand_ready = 1'b0;
    bit busy_mode = 1'b0;
    bit prev_stall = 1'b0;
    bit prev_tick = 1'b0;
    logic [7:0] prev_addr = 8'd0;
    int cyc;

    snn_inference_sequencer dut (
        .ACLK          (clk),
        .ARESET        (areset),
        .IMAGE         (image),
        .NEW_IMAGE     (new_image),
        .EVT_VALID     (evt_valid),
        .EVT_ADDR      (evt_addr),
        .EVT_READY     (evt_ready),
        .TICK          (tick),
        .CORE_BUSY     (core_busy),
        .OUT_SPK_VALID (out_spk_valid),
        .OUT_SPK_ADDR  (out_spk_addr),
        .INFERED_DIGIT (infered_digit),
        .COP_RDY       (cop_rdy)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Core / handshake model: random ready and a 20-cycle busy window after each tick.
    initial forever begin
        @(posedge clk);
        #1;
        evt_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        if (busy_mode && tick) busy_left = 20;
        core_busy = (busy_left > 0);
        if (busy_left > 0) busy_left--;
    end

    always @(negedge clk) begin
        if (evt_valid && evt_ready) evt_cnt++;
        if (evt_valid) valid_cycles++;
        if (tick) tick_cnt++;
        if (tick && prev_tick) tick_err++;
        if (prev_stall && (!evt_valid || evt_addr != prev_addr)) stall_err++;
        if (evt_valid && !evt_ready) stall_seen++;
        if (core_busy && evt_valid) busy_overlap++;
        prev_tick  = tick;
        prev_stall = evt_valid && !evt_ready;
        prev_addr  = evt_addr;
    end

    task automatic fill_image(input logic [7:0] v);
        for (int i = 0; i < 256; i++) image[i] = v;
    endtask

    task automatic start_run();
        new_image = 1'b0;
        wait_clk(1);
        evt_cnt = 0; valid_cycles = 0; tick_cnt = 0; tick_err = 0;
        stall_err = 0; stall_seen = 0; busy_overlap = 0;
        new_image = 1'b1;
        wait_clk(1);
    endtask

    task automatic inject(input logic [7:0] addr, input int n);
        out_spk_addr  = addr;
        out_spk_valid = 1'b1;
        wait_clk(n);
        out_spk_valid = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        cyc = 0;
        while (!cop_rdy && cyc < limit) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("run_timeout", cop_rdy, 1);
    endtask

    initial begin
        fill_image(8'h00);
        wait_clk(3);
        areset = 1'b0;
        check("rst_cop_rdy", cop_rdy, 1);
        check("rst_digit", infered_digit, 8'hFF);
        check("rst_evt_valid", evt_valid, 0);
        check("rst_evt_addr", evt_addr, 0);
        check("rst_tick", tick, 0);

        // Full-brightness image: pixels fire on t = 0..14.
        fill_image(8'hFF);
        start_run();
        check("ff_first_valid", evt_valid, 1);
        check("ff_busy_rdy", cop_rdy, 0);
        check("ff_digit_cleared", infered_digit, 8'hFF);
        wait_done(6000);
        check("ff_events", evt_cnt, 15 * 256);
        check("ff_ticks", tick_cnt, 16);
        check("ff_tick_width", tick_err, 0);
        check("ff_digit", infered_digit, 8'hFF);
        check("ff_cycles", cyc, 4138);

        // Dark image: no events, 258 cycles per timestep plus 10 argmax cycles.
        fill_image(8'h00);
        start_run();
        wait_done(6000);
        check("zero_valid_cycles", valid_cycles, 0);
        check("zero_ticks", tick_cnt, 16);
        check("zero_cycles", cyc, 4138);
        check("zero_digit", infered_digit, 8'hFF);
        new_image = 1'b0;
        wait_clk(5);
        check("done_hold_rdy", cop_rdy, 1);
        check("done_hold_digit", infered_digit, 8'hFF);

        // Tie between class 3 and 7 resolves low; out-of-range addresses ignored.
        start_run();
        inject(8'd3, 5);
        inject(8'd7, 5);
        inject(8'd1, 2);
        inject(8'd12, 20);
        inject(8'h11, 10);
        wait_done(6000);
        check("tie_digit", infered_digit, 3);
        check("tie_rdy", cop_rdy, 1);

        // Spikes landing during the argmax scan must be dropped.
        start_run();
        inject(8'd2, 3);
        wait_clk(4125);
        inject(8'd9, 9);
        wait_done(100);
        check("argmax_drop_digit", infered_digit, 2);

        // Saturation: 300 spikes stay at 255, beating 100.
        start_run();
        inject(8'd2, 300);
        inject(8'd4, 100);
        wait_done(6000);
        check("sat_digit", infered_digit, 2);

        // Back-pressure and a busy core.
        fill_image(8'hFF);
        rand_ready = 1'b1;
        busy_mode  = 1'b1;
        start_run();
        wait_done(20000);
        check("stall_events", evt_cnt, 15 * 256);
        check("stall_ticks", tick_cnt, 16);
        check("stall_hold", stall_err, 0);
        check("stall_seen", stall_seen > 0, 1);
        check("busy_overlap", busy_overlap, 0);
        check("stall_digit", infered_digit, 8'hFF);
        rand_ready = 1'b0;
        busy_mode  = 1'b0;
        wait_clk(25);

        // Eight class-5 spikes during timestep 2.
        fill_image(8'h00);
        start_run();
        wait_clk(2 * 258 + 10);
        inject(8'd5, 8);
        wait_done(6000);
        check("early_digit", infered_digit, 5);
`ifdef SNN_SEQ_EARLY_STOP_EN
        check("early_ticks", tick_cnt, 3);
`else
        check("early_ticks", tick_cnt, 16);
`endif

        // Mid-run rising edge is ignored; reset aborts the run.
        fill_image(8'hFF);
        start_run();
        wait_clk(40);
        new_image = 1'b0;
        wait_clk(1);
        new_image = 1'b1;
        wait_clk(2);
        check("toggle_addr", evt_addr, 43);
        check("toggle_valid", evt_valid, 1);
        check("toggle_busy", cop_rdy, 0);
        wait_clk(5);
        areset    = 1'b1;
        new_image = 1'b0;
        wait_clk(1);
        areset = 1'b0;
        check("abort_rdy", cop_rdy, 1);
        check("abort_digit", infered_digit, 8'hFF);
        check("abort_valid", evt_valid, 0);
        check("abort_addr", evt_addr, 0);
        wait_clk(10);
        check("abort_idle_valid", evt_valid, 0);
        check("abort_idle_tick", tick, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
